// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame controller between the codec sample stream and the FFT core.
// It fills the core buffer with one frame of samples, pulses the core start, waits
// for the core to finish and streams the bins out over a valid/ready handshake.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   enable              run frames while high
//   cfg_*               depth / mode / direction, latched when a frame starts
//   s_valid/s_real/s_imag  input sample strobe and data
//   ovr_clear, overrun  sticky dropped-sample flag and its clear
//   ctl_*               core control: start pulse, latched config, ready/done, scaling
//   data_*              core buffer port: shared address, write port, read request/response
//   m_*                 output bin stream (valid/ready) with index, last flag and scaling
//   frame_count         completed frames, wraps
module fft_frame_ctrl #(
    parameter int NB          = 18,
    parameter int LOG_DEPTH   = 10,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             cfg_log_depth,
    input  logic                   cfg_real_mode,
    input  logic                   cfg_direction,
    input  logic                   s_valid,
    input  logic [NB-1:0]          s_real,
    input  logic [NB-1:0]          s_imag,
    input  logic                   ovr_clear,
    input  logic                   ctl_ready,
    output logic                   ctl_start,
    output logic [3:0]             ctl_log_depth,
    output logic                   ctl_real_mode,
    output logic                   ctl_direction,
    input  logic                   ctl_done,
    input  logic [3:0]             ctl_output_scaling,
    output logic [LOG_DEPTH-1:0]   data_address,
    output logic                   data_write_enable,
    output logic [2*NB-1:0]        data_write_data,
    output logic                   data_read_enable,
    input  logic                   data_read_valid,
    input  logic [2*NB-1:0]        data_read_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NB-1:0]          m_real,
    output logic [NB-1:0]          m_imag,
    output logic [LOG_DEPTH-1:0]   m_bin,
    output logic                   m_last,
    output logic [3:0]             m_scaling,
    output logic                   overrun,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    localparam logic [3:0] MAX_LD = 4'(LOG_DEPTH);
    localparam logic [3:0] MIN_LD = 4'd3;

    state_t                 state_q;
    logic [3:0]             log_depth_q;
    logic                   real_mode_q;
    logic                   direction_q;
    logic [LOG_DEPTH-1:0]   addr_q;
    logic                   m_valid_q;
    logic [NB-1:0]          m_real_q;
    logic [NB-1:0]          m_imag_q;
    logic [LOG_DEPTH-1:0]   m_bin_q;
    logic                   m_last_q;
    logic [3:0]             m_scaling_q;
    logic                   overrun_q;
    logic [FRAME_CNT_W-1:0] frame_count_q;

    logic [3:0]             log_depth_d;
    logic [LOG_DEPTH-1:0]   fill_last_s;
    logic [LOG_DEPTH-1:0]   out_last_s;
    logic                   wr_s;

    // Clamp the requested depth into the range the core buffer supports.
    always_comb begin
        if (cfg_log_depth < MIN_LD) begin
            log_depth_d = MIN_LD;
        end else if (cfg_log_depth > MAX_LD) begin
            log_depth_d = MAX_LD;
        end else begin
            log_depth_d = cfg_log_depth;
        end
    end

    // Last fill address is N-1 (low log_depth bits set); a shift by the full
    // width leaves zero, so the inversion yields all ones at maximum depth.
    always_comb begin
        fill_last_s = ~({LOG_DEPTH{1'b1}} << log_depth_q);
        if (real_mode_q) begin
            out_last_s = fill_last_s >> 1;
        end else begin
            out_last_s = fill_last_s;
        end
    end

    assign wr_s = (state_q == S_FILL) && s_valid;

    // Buffer port and start pulse; the write path is combinational so a sample
    // lands in the same cycle as its strobe.
    always_comb begin
        data_write_enable = wr_s;
        data_read_enable  = (state_q == S_RD_REQ);
        ctl_start         = (state_q == S_START) && ctl_ready;
        if (wr_s) begin
            data_write_data = {(real_mode_q ? {NB{1'b0}} : s_imag), s_real};
        end else begin
            data_write_data = {(2*NB){1'b0}};
        end
        case (state_q)
            S_FILL, S_RD_REQ: data_address = addr_q;
            default:          data_address = {LOG_DEPTH{1'b0}};
        endcase
    end

    // Frame FSM with config latch, overrun flag, output bin register and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            log_depth_q   <= 4'd0;
            real_mode_q   <= 1'b0;
            direction_q   <= 1'b0;
            addr_q        <= {LOG_DEPTH{1'b0}};
            m_valid_q     <= 1'b0;
            m_real_q      <= {NB{1'b0}};
            m_imag_q      <= {NB{1'b0}};
            m_bin_q       <= {LOG_DEPTH{1'b0}};
            m_last_q      <= 1'b0;
            m_scaling_q   <= 4'd0;
            overrun_q     <= 1'b0;
            frame_count_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            // A drop in the same cycle as a clear keeps the flag set.
            if (s_valid && (state_q != S_FILL)) begin
                overrun_q <= 1'b1;
            end else if (ovr_clear) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        log_depth_q <= log_depth_d;
                        real_mode_q <= cfg_real_mode;
                        direction_q <= cfg_direction;
                        addr_q      <= {LOG_DEPTH{1'b0}};
                        state_q     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (s_valid) begin
                        if (addr_q == fill_last_s) begin
                            addr_q  <= {LOG_DEPTH{1'b0}};
                            state_q <= S_START;
                        end else begin
                            addr_q <= addr_q + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_START: begin
                    if (ctl_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ctl_done) begin
                        m_scaling_q <= ctl_output_scaling;
                        addr_q      <= {LOG_DEPTH{1'b0}};
                        state_q     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (data_read_valid) begin
                        m_real_q  <= data_read_data[NB-1:0];
                        m_imag_q  <= data_read_data[2*NB-1:NB];
                        m_bin_q   <= addr_q;
                        m_last_q  <= (addr_q == out_last_s);
                        m_valid_q <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (m_last_q) begin
                            frame_count_q <= frame_count_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
                            state_q       <= S_IDLE;
                        end else begin
                            addr_q  <= addr_q + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctl_log_depth = log_depth_q;
    assign ctl_real_mode = real_mode_q;
    assign ctl_direction = direction_q;
    assign m_valid       = m_valid_q;
    assign m_real        = m_real_q;
    assign m_imag        = m_imag_q;
    assign m_bin         = m_bin_q;
    assign m_last        = m_last_q;
    assign m_scaling     = m_scaling_q;
    assign overrun       = overrun_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a table of frame scenarios drives a behavioural core
// (buffer memory with configurable read latency, done pulse after start) while
// write and bin scoreboards check everything the block produces.
module tb_fft_frame_ctrl;
    localparam int NB = 18;
    localparam int LD = 10;
    localparam int FW = 16;
    localparam int DONE_LAT = 10;

    logic clk = 1'b0;
    logic reset, enable, cfg_real_mode, cfg_direction, s_valid, ovr_clear, ctl_ready;
    logic [3:0] cfg_log_depth, ctl_output_scaling;
    logic [NB-1:0] s_real, s_imag;
    logic ctl_start, ctl_real_mode, ctl_direction, ctl_done;
    logic [3:0] ctl_log_depth, m_scaling;
    logic [LD-1:0] data_address, m_bin;
    logic data_write_enable, data_read_enable, data_read_valid;
    logic [2*NB-1:0] data_write_data, data_read_data;
    logic m_valid, m_ready, m_last, overrun;
    logic [NB-1:0] m_real, m_imag;
    logic [FW-1:0] frame_count;

    fft_frame_ctrl #(.NB(NB), .LOG_DEPTH(LD), .FRAME_CNT_W(FW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_log_depth(cfg_log_depth),
        .cfg_real_mode(cfg_real_mode), .cfg_direction(cfg_direction), .s_valid(s_valid),
        .s_real(s_real), .s_imag(s_imag), .ovr_clear(ovr_clear), .ctl_ready(ctl_ready),
        .ctl_start(ctl_start), .ctl_log_depth(ctl_log_depth), .ctl_real_mode(ctl_real_mode),
        .ctl_direction(ctl_direction), .ctl_done(ctl_done), .ctl_output_scaling(ctl_output_scaling),
        .data_address(data_address), .data_write_enable(data_write_enable),
        .data_write_data(data_write_data), .data_read_enable(data_read_enable),
        .data_read_valid(data_read_valid), .data_read_data(data_read_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_bin(m_bin), .m_last(m_last), .m_scaling(m_scaling), .overrun(overrun),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cfg_ld;
        logic       real_m;
        logic       dir;
        int         gap;
        logic [3:0] exp_ld;
        int         stall_bin;
        int         rd_lat;
        logic [3:0] scale;
        int         ready_low;
        bit         do_ovr;
        int         rst_after;
    } vec_t;

    typedef struct { logic [LD-1:0] addr; logic [2*NB-1:0] data; } wr_t;
    typedef struct { logic [NB-1:0] re; logic [NB-1:0] im; logic [LD-1:0] bin; logic last; logic [3:0] sc; } bin_t;

    wr_t  wq[$];
    bin_t bq[$];
    logic [2*NB-1:0] mem [0:(1<<LD)-1];

    int n_vec = 0;
    int n_miss = 0;
    int start_cnt = 0;
    int exp_frames = 0;
    int cur_rd_lat = 1;
    logic [3:0] cur_scale = 4'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor plus behavioural core, both sampled on the falling edge.
    initial begin : monitor_and_core
        int rd_pend, done_pend;
        logic [LD-1:0] rd_addr;
        wr_t  w;
        bin_t b;
        rd_pend = 0; done_pend = 0; rd_addr = '0;
        ctl_done = 1'b0; data_read_valid = 1'b0; data_read_data = '0; ctl_output_scaling = 4'd0;
        forever begin
            @(negedge clk);
            ctl_done = 1'b0; data_read_valid = 1'b0; ctl_output_scaling = 4'd0;
            if (!reset) begin
                rd_pend = 0; done_pend = 0;
            end else begin
                if (data_write_enable) begin
                    if (wq.size() == 0) begin
                        check("unexpected_write", 64'(data_address), 64'hFFFF);
                    end else begin
                        w = wq.pop_front();
                        check("write_addr", 64'(data_address), 64'(w.addr));
                        check("write_data", 64'(data_write_data), 64'(w.data));
                    end
                    mem[data_address] = data_write_data;
                end
                if (data_write_enable && data_read_enable) check("wr_rd_exclusive", 64'd1, 64'd0);
                if (ctl_start) begin
                    start_cnt++;
                    check("start_needs_ready", 64'(ctl_ready), 64'd1);
                end
                if (data_read_enable) check("read_while_holding", 64'(m_valid), 64'd0);
                if (m_valid && m_ready) begin
                    if (bq.size() == 0) begin
                        check("unexpected_bin", 64'(m_bin), 64'hFFFF);
                    end else begin
                        b = bq.pop_front();
                        check("bin_real", 64'(m_real), 64'(b.re));
                        check("bin_imag", 64'(m_imag), 64'(b.im));
                        check("bin_index", 64'(m_bin), 64'(b.bin));
                        check("bin_last", 64'(m_last), 64'(b.last));
                        check("bin_scaling", 64'(m_scaling), 64'(b.sc));
                    end
                end
                if (done_pend > 0) begin
                    done_pend--;
                    if (done_pend == 0) begin ctl_done = 1'b1; ctl_output_scaling = cur_scale; end
                end
                if (rd_pend > 0) begin
                    rd_pend--;
                    if (rd_pend == 0) begin data_read_valid = 1'b1; data_read_data = mem[rd_addr]; end
                end
                if (ctl_start) done_pend = DONE_LAT;
                if (data_read_enable) begin rd_pend = cur_rd_lat; rd_addr = data_address; end
            end
        end
    end

    function automatic logic [NB-1:0] samp_re(input int idx, input int k);
        return NB'(k + idx * 1000);
    endfunction

    function automatic logic [NB-1:0] samp_im(input int idx, input int k);
        return NB'(-k - idx * 3);
    endfunction

    task automatic drive_samples(input vec_t v, input int idx, input int count, input bit main_pass);
        int nout;
        wr_t w;
        bin_t b;
        nout = v.real_m ? (1 << (v.exp_ld - 1)) : (1 << v.exp_ld);
        for (int k = 0; k < count; k++) begin
            s_valid = 1'b1;
            s_real  = samp_re(idx, k);
            s_imag  = samp_im(idx, k);
            w.addr = LD'(k);
            w.data = {(v.real_m ? {NB{1'b0}} : s_imag), s_real};
            wq.push_back(w);
            if (main_pass && k < nout) begin
                b.re = s_real; b.im = v.real_m ? {NB{1'b0}} : s_imag;
                b.bin = LD'(k); b.last = (k == nout - 1); b.sc = v.scale;
                bq.push_back(b);
            end
            if (main_pass && k == count / 2) begin
                cfg_log_depth = 4'd5; cfg_real_mode = ~v.real_m; cfg_direction = ~v.dir;
            end
            tick();
            s_valid = 1'b0;
            repeat (v.gap) tick();
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int snap, stall_n;
        bit done;
        logic [NB-1:0] h_re, h_im;
        logic [LD-1:0] h_bin;
        cur_rd_lat = v.rd_lat; cur_scale = v.scale;
        ctl_ready = (v.ready_low == 0);
        snap = start_cnt;
        cfg_log_depth = v.cfg_ld; cfg_real_mode = v.real_m; cfg_direction = v.dir;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        if (v.rst_after != 0) begin
            drive_samples(v, idx, v.rst_after, 1'b0);
            check("partial_writes", 64'(wq.size()), 64'd0);
            reset = 1'b0;
            #1;
            check("rst_write_en", 64'(data_write_enable), 64'd0);
            check("rst_start", 64'(ctl_start), 64'd0);
            check("rst_addr", 64'(data_address), 64'd0);
            check("rst_frame_count", 64'(frame_count), 64'd0);
            check("rst_ctl_depth", 64'(ctl_log_depth), 64'd0);
            exp_frames = 0;
            tick(); tick();
            check("rst_no_start", 64'(start_cnt - snap), 64'd0);
            enable = 1'b1;
            reset = 1'b1;
            tick();
            enable = 1'b0;
        end
        check("latch_depth", 64'(ctl_log_depth), 64'(v.exp_ld));
        check("latch_mode", 64'(ctl_real_mode), 64'(v.real_m));
        check("latch_dir", 64'(ctl_direction), 64'(v.dir));
        drive_samples(v, idx, 1 << v.exp_ld, 1'b1);
        check("held_depth", 64'(ctl_log_depth), 64'(v.exp_ld));
        check("held_mode", 64'(ctl_real_mode), 64'(v.real_m));
        check("held_dir", 64'(ctl_direction), 64'(v.dir));
        if (v.ready_low != 0) begin
            repeat (v.ready_low) tick();
            check("no_start_while_busy", 64'(start_cnt - snap), 64'd0);
            ctl_ready = 1'b1;
        end
        if (v.do_ovr) begin
            tick(); tick();
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            check("drop_in_wait", 64'(overrun), 64'd1);
        end
        done = 1'b0; stall_n = 0; h_re = '0; h_im = '0; h_bin = '0;
        for (int c = 0; c < 20000 && !done; c++) begin
            m_ready = 1'b1;
            if (m_valid && int'(m_bin) == v.stall_bin && stall_n < 5) begin
                m_ready = 1'b0;
                if (stall_n == 0) begin
                    h_re = m_real; h_im = m_imag; h_bin = m_bin;
                end else begin
                    check("stall_real", 64'(m_real), 64'(h_re));
                    check("stall_imag", 64'(m_imag), 64'(h_im));
                    check("stall_bin", 64'(m_bin), 64'(h_bin));
                end
                stall_n++;
            end
            tick();
            if (frame_count == FW'(exp_frames + 1) && bq.size() == 0) done = 1'b1;
        end
        m_ready = 1'b1;
        if (!done) check("frame_timeout", 64'd0, 64'd1);
        exp_frames++;
        tick();
        check("frame_count", 64'(frame_count), 64'(exp_frames));
        check("bins_pending", 64'(bq.size()), 64'd0);
        check("writes_pending", 64'(wq.size()), 64'd0);
        check("start_pulses", 64'(start_cnt - snap), 64'd1);
        check("idle_addr", 64'(data_address), 64'd0);
        check("overrun_after", 64'(overrun), 64'(v.do_ovr));
        if (v.do_ovr) begin
            ovr_clear = 1'b1;
            tick();
            ovr_clear = 1'b0;
            check("ovr_clear", 64'(overrun), 64'd0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{cfg_ld:4'd3,  real_m:1'b0, dir:1'b0, gap:0, exp_ld:4'd3,  stall_bin:-1, rd_lat:1, scale:4'd5,  ready_low:0, do_ovr:1'b1, rst_after:0};
        vecs[1] = '{cfg_ld:4'd4,  real_m:1'b1, dir:1'b1, gap:2, exp_ld:4'd4,  stall_bin:2,  rd_lat:3, scale:4'd9,  ready_low:0, do_ovr:1'b0, rst_after:0};
        vecs[2] = '{cfg_ld:4'd15, real_m:1'b1, dir:1'b0, gap:0, exp_ld:4'd10, stall_bin:-1, rd_lat:2, scale:4'd2,  ready_low:0, do_ovr:1'b0, rst_after:0};
        vecs[3] = '{cfg_ld:4'd1,  real_m:1'b0, dir:1'b1, gap:1, exp_ld:4'd3,  stall_bin:-1, rd_lat:1, scale:4'd15, ready_low:4, do_ovr:1'b0, rst_after:0};
        vecs[4] = '{cfg_ld:4'd3,  real_m:1'b0, dir:1'b0, gap:0, exp_ld:4'd3,  stall_bin:5,  rd_lat:2, scale:4'd7,  ready_low:0, do_ovr:1'b0, rst_after:4};

        reset = 1'b0; enable = 1'b0; cfg_log_depth = 4'd0; cfg_real_mode = 1'b0; cfg_direction = 1'b0;
        s_valid = 1'b0; s_real = '0; s_imag = '0; ovr_clear = 1'b0; ctl_ready = 1'b1; m_ready = 1'b1;
        tick(); tick();
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_frame_count", 64'(frame_count), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_start", 64'(ctl_start), 64'd0);
        check("reset_addr", 64'(data_address), 64'd0);
        check("reset_ctl_depth", 64'(ctl_log_depth), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        // Overrun in IDLE, clear, and drop-beats-clear in the same cycle.
        s_valid = 1'b1; tick(); s_valid = 1'b0;
        check("drop_in_idle", 64'(overrun), 64'd1);
        ovr_clear = 1'b1; tick(); ovr_clear = 1'b0;
        check("clear_idle", 64'(overrun), 64'd0);
        s_valid = 1'b1; tick();
        ovr_clear = 1'b1; tick();
        s_valid = 1'b0; ovr_clear = 1'b0;
        check("set_wins_clear", 64'(overrun), 64'd1);
        ovr_clear = 1'b1; tick(); ovr_clear = 1'b0;
        check("final_clear", 64'(overrun), 64'd0);
        check("no_stray_writes", 64'(wq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
